// File: rtl/channel_frame_buffer_pkg.sv
// Shared sizing helpers, sample type and ADAT constants for the frame buffer.
package channel_frame_buffer_pkg;

    localparam int ADAT_CHANNELS        = 8;
    localparam int ADAT_SAMPLE_WIDTH    = 24;
    localparam int DEFAULT_SAMPLE_WIDTH = ADAT_SAMPLE_WIDTH;

    typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

    function automatic int chan_width(input int num_channels);
        return (num_channels <= 1) ? 1 : $clog2(num_channels);
    endfunction

    function automatic int level_width(input int depth_frames);
        return $clog2(depth_frames) + 1;
    endfunction

    function automatic int addr_width(input int depth_frames, input int num_channels);
        return $clog2(depth_frames) + chan_width(num_channels);
    endfunction

endpackage

// File: rtl/simple_dual_port_ram_single_clock.sv
// One write port, one registered read port, single clock; contents are never reset.
module simple_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/channel_frame_buffer.sv
// Circular buffer of whole multi-channel frames with frame commit, resync,
// overflow drop and zero-filled underrun frames.
module channel_frame_buffer
    import channel_frame_buffer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int NUM_CHANNELS = ADAT_CHANNELS,
    parameter int DEPTH_FRAMES = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_valid_i,
    input  logic                                  wr_sync_i,
    input  logic [SAMPLE_WIDTH-1:0]               wr_data_i,
    input  logic                                  rd_req_i,
    output logic                                  rd_valid_o,
    output logic [SAMPLE_WIDTH-1:0]               rd_data_o,
    output logic [chan_width(NUM_CHANNELS)-1:0]   rd_chan_o,
    output logic [level_width(DEPTH_FRAMES)-1:0]  level_o,
    output logic                                  overflow_o,
    output logic                                  underflow_o,
    output logic                                  resync_o
);

    localparam int CHW = chan_width(NUM_CHANNELS);
    localparam int FW  = level_width(DEPTH_FRAMES);
    localparam int PW  = $clog2(DEPTH_FRAMES);
    localparam int AW  = addr_width(DEPTH_FRAMES, NUM_CHANNELS);

    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CHANNELS - 1);
    localparam logic [FW-1:0]  FULL    = FW'(DEPTH_FRAMES);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CHW-1:0] wr_chan_q, wr_chan_d, rd_chan_q, rd_chan_d;
    logic [CHW-1:0] rd_chan_out_q, rd_chan_out_d;
    logic [FW-1:0]  level_q, level_d;
    logic           drop_q, drop_d;
    logic           rd_under_q, rd_under_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_zero_q, rd_zero_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic           resync_q, resync_d;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr, ram_raddr;
    logic [SAMPLE_WIDTH-1:0] ram_rdata;
    logic [CHW-1:0] wr_chan_eff;
    logic           wr_drop, rd_under_eff, commit, consume;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_chan_d     = wr_chan_q;
        rd_chan_d     = rd_chan_q;
        rd_chan_out_d = rd_chan_out_q;
        drop_d        = drop_q;
        rd_under_d    = rd_under_q;
        rd_valid_d    = rd_req_i;
        rd_zero_d     = 1'b0;
        overflow_d    = 1'b0;
        underflow_d   = 1'b0;
        resync_d      = 1'b0;
        ram_we        = 1'b0;
        commit        = 1'b0;
        consume       = 1'b0;

        // A sync marker always restarts the frame at channel 0 in the current slot.
        wr_chan_eff = wr_sync_i ? '0 : wr_chan_q;
        wr_drop     = drop_q;
        if (wr_valid_i) begin
            resync_d = wr_sync_i && (wr_chan_q != '0);
            if (wr_chan_eff == '0) begin
                wr_drop    = (level_q == FULL);
                drop_d     = wr_drop;
                overflow_d = wr_drop;
            end
            ram_we    = !wr_drop;
            commit    = !wr_drop && (wr_chan_eff == LAST_CH);
            wr_chan_d = (wr_chan_eff == LAST_CH) ? '0 : wr_chan_eff + CHW'(1);
        end
        if (commit) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        rd_under_eff = rd_under_q;
        if (rd_req_i) begin
            if (rd_chan_q == '0) begin
                rd_under_eff = (level_q == '0);
                rd_under_d   = rd_under_eff;
                underflow_d  = rd_under_eff;
            end
            consume       = !rd_under_eff && (rd_chan_q == LAST_CH);
            rd_zero_d     = rd_under_eff;
            rd_chan_out_d = rd_chan_q;
            rd_chan_d     = (rd_chan_q == LAST_CH) ? '0 : rd_chan_q + CHW'(1);
        end
        if (consume) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        level_d   = level_q + FW'(commit) - FW'(consume);
        ram_waddr = {wr_ptr_q, wr_chan_eff};
        ram_raddr = {rd_ptr_q, rd_chan_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_chan_q     <= '0;
            rd_chan_q     <= '0;
            rd_chan_out_q <= '0;
            level_q       <= '0;
            drop_q        <= 1'b0;
            rd_under_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_zero_q     <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            resync_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_chan_q     <= wr_chan_d;
            rd_chan_q     <= rd_chan_d;
            rd_chan_out_q <= rd_chan_out_d;
            level_q       <= level_d;
            drop_q        <= drop_d;
            rd_under_q    <= rd_under_d;
            rd_valid_q    <= rd_valid_d;
            rd_zero_q     <= rd_zero_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            resync_q      <= resync_d;
        end
    end

    simple_dual_port_ram_single_clock #(
        .DATA_WIDTH(SAMPLE_WIDTH),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(wr_data_i),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    // Underrun frames and idle cycles present zero instead of stale RAM output.
    assign rd_data_o   = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
    assign rd_valid_o  = rd_valid_q;
    assign rd_chan_o   = rd_chan_out_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign resync_o    = resync_q;

endmodule
